encoder2_rr: RTL and testbench

- Sequential 4-to-2 round-robin encoder; the inverse of the team's 2-to-4 enable decoder.
- Captures single-cycle request strobes on 4 one-hot/multi-hot lines and holds them as pending.
- Emits each pending request, one at a time, as a 2-bit index S with a valid/ready handshake.
- Output S feeds directly into a decoder2 S input downstream, so out[S] regenerates the original line.

---
 rtl/encoder2_rr.sv | 95 +++++++++
 tb/tb_encoder2_rr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder2_rr.sv
// Round-robin 4-to-2 encoder: captures request strobes as pending bits and issues
// them one at a time as a 2-bit index over a valid/ready handshake.
//
// state | meaning
// IDLE  | nothing presented; issue the first pending line found from ptr
// VALID | S holds an unaccepted index; on accept, issue the next line after S or drop valid
module encoder2_rr (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] S,
  output logic       valid,
  output logic [3:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;

  logic [1:0] scan_start;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] sel;
  logic       issue;
  logic [3:0] issue_mask;
  logic [3:0] cap;

  // On a handshake the scan starts just after the index being accepted,
  // which is exactly the pointer value that edge will store.
  always_comb begin
    scan_start = (state == VALID) ? S + 2'd1 : ptr;

    rot = pending;
    case (scan_start)
      2'd0:    rot = pending;
      2'd1:    rot = {pending[0],   pending[3:1]};
      2'd2:    rot = {pending[1:0], pending[3:2]};
      default: rot = {pending[2:0], pending[3]};
    endcase

    off = 2'd3;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;

    sel        = scan_start + off;
    issue      = (pending != 4'b0000) && ((state == IDLE) || ready);
    issue_mask = issue ? (4'b0001 << sel) : 4'b0000;
    cap        = enable ? req : 4'b0000;
  end

  // A request landing on the bit being issued re-arms it as a fresh request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      S       <= 2'd0;
      valid   <= 1'b0;
      pending <= 4'b0000;
    end else begin
      pending <= (pending & ~issue_mask) | cap;
      case (state)
        IDLE: begin
          if (issue) begin
            S     <= sel;
            valid <= 1'b1;
            state <= VALID;
          end
        end
        VALID: begin
          if (ready) begin
            ptr <= S + 2'd1;
            if (issue) begin
              S <= sel;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder2_rr.sv
// Bench for encoder2_rr: a cycle-level reference model predicts each issued index
// into a queue; a monitor pops and compares whenever the DUT presents valid.
module tb_encoder2_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ready = 1'b0;
  logic [1:0] S;
  logic       valid;
  logic [3:0] pending;

  int n_vec = 0;
  int n_err = 0;

  bit m_pend[4];
  bit m_valid = 1'b0;
  int m_s = 0;
  int m_ptr = 0;
  int q[$];

  encoder2_rr dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .ready(ready),
    .S(S), .valid(valid), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input int start);
    for (int k = 0; k < 4; k++) begin
      if (m_pend[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Reference model: pending set, rotating start, one index presented at a time.
  always @(posedge clk or negedge reset) begin : model
    int iss;
    if (!reset) begin
      m_valid = 1'b0;
      m_s = 0;
      m_ptr = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      q.delete();
    end else begin
      iss = -1;
      if (!m_valid) begin
        iss = first_from(m_ptr);
        if (iss >= 0) begin
          m_valid = 1'b1;
          m_s = iss;
        end
      end else if (ready) begin
        m_ptr = (m_s + 1) % 4;
        iss = first_from(m_ptr);
        if (iss >= 0) m_s = iss;
        else m_valid = 1'b0;
      end
      if (iss >= 0) begin
        m_pend[iss] = 1'b0;
        q.push_back(iss);
      end
      if (enable) begin
        for (int i = 0; i < 4; i++) if (req[i]) m_pend[i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("valid", {3'b0, valid}, {3'b0, m_valid});
      chk("pending", pending, pend_vec());
      if (valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL S_unexpected: got %0d, expected no valid output", S);
        end else begin
          chk("S", {2'b0, S}, 4'(q[0]));
          if (ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // reset holds everything at zero regardless of req
    reset = 1'b0; enable = 1'b1; req = 4'b1111; ready = 1'b0;
    repeat (3) cyc();
    chk("rst_pending", pending, 4'b0000);
    chk("rst_valid", {3'b0, valid}, 4'b0000);
    chk("rst_S", {2'b0, S}, 4'b0000);
    reset = 1'b1; req = 4'b0000;
    repeat (2) cyc();
    chk("rel_pending", pending, 4'b0000);
    chk("rel_valid", {3'b0, valid}, 4'b0000);

    // single request, two-edge latency
    ready = 1'b1; req = 4'b0100;
    cyc(); req = 4'b0000;
    chk("single_e1_pending", pending, 4'b0100);
    chk("single_e1_valid", {3'b0, valid}, 4'b0000);
    cyc();
    chk("single_e2_valid", {3'b0, valid}, 4'b0001);
    chk("single_e2_S", {2'b0, S}, 4'd2);
    chk("single_e2_pending", pending, 4'b0000);
    cyc();
    chk("single_e3_valid", {3'b0, valid}, 4'b0000);

    // full burst twice from ptr=0
    pulse_reset();
    ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      req = 4'b1111;
      cyc(); req = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        cyc();
        chk("burst_S", {2'b0, S}, 4'(k));
        chk("burst_valid", {3'b0, valid}, 4'b0001);
      end
      cyc();
      chk("burst_end_valid", {3'b0, valid}, 4'b0000);
    end

    // backpressure holds S and valid
    ready = 1'b0; req = 4'b1010;
    cyc(); req = 4'b0000;
    repeat (5) cyc();
    chk("bp_S", {2'b0, S}, 4'd1);
    chk("bp_valid", {3'b0, valid}, 4'b0001);
    chk("bp_pending", pending, 4'b1000);
    ready = 1'b1;
    cyc();
    chk("bp_next_S", {2'b0, S}, 4'd3);
    cyc();
    chk("bp_end_valid", {3'b0, valid}, 4'b0000);

    // rotation fairness and set-wins on the issued bit
    req = 4'b0010;
    cyc(); req = 4'b0000;
    repeat (2) cyc();
    req = 4'b0011;
    cyc(); req = 4'b0001;
    cyc(); req = 4'b0000;
    chk("rot_first_S", {2'b0, S}, 4'd0);
    chk("rot_setwins_pending", pending, 4'b0011);
    cyc();
    chk("rot_second_S", {2'b0, S}, 4'd1);
    cyc();
    chk("rot_third_S", {2'b0, S}, 4'd0);
    cyc();
    chk("rot_end_valid", {3'b0, valid}, 4'b0000);

    // enable=0 ignores req but the handshake still completes
    ready = 1'b0; req = 4'b0100;
    cyc(); req = 4'b0000;
    cyc();
    enable = 1'b0; req = 4'b1111; ready = 1'b1;
    cyc();
    chk("en_pending", pending, 4'b0000);
    chk("en_valid", {3'b0, valid}, 4'b0000);
    enable = 1'b1; req = 4'b0000;

    // asynchronous reset mid-burst
    ready = 1'b0; req = 4'b1111;
    cyc(); req = 4'b0000;
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_valid", {3'b0, valid}, 4'b0000);
    chk("async_pending", pending, 4'b0000);
    chk("async_S", {2'b0, S}, 4'b0000);
    cyc();
    reset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      enable = ($urandom_range(0, 7) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // drain with a bounded wait
    enable = 1'b0; req = 4'b0000; ready = 1'b1;
    budget = 0;
    while ((valid || q.size() != 0 || pending != 4'b0000) && budget < 50) begin
      cyc();
      budget++;
    end
    chk("drain_in_budget", {3'b0, (budget < 50)}, 4'b0001);
    chk("drain_queue_empty", 4'(q.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
